// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequenced 8x8 nibble multiplier.
// The cross-term accumulation mode is selected by MULT_SEQ_APPROX_ACC_EN in the controller.
package mult_seq_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;

    localparam int unsigned SH_P0    = 0;
    localparam int unsigned SH_CROSS = 4;
    localparam int unsigned SH_P3    = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL0 = 3'd1,
        ST_MUL1 = 3'd2,
        ST_MUL2 = 3'd3,
        ST_MUL3 = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/LM_2.sv
// Approximate 4x4 nibble multiplier built from four 2x2 blocks in which 3x3 yields 7.
// Purely combinational; the controller consumes its output in the same cycle.
module LM_2 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_r_c
);

    function automatic logic [2:0] mul2(input logic [1:0] x, input logic [1:0] y);
        mul2 = {x[1] & y[1], (x[1] & y[0]) | (x[0] & y[1]), x[0] & y[0]};
    endfunction

    logic [2:0] w_ll;
    logic [2:0] w_lh;
    logic [2:0] w_hl;
    logic [2:0] w_hh;

    assign w_ll = mul2(i_a[1:0], i_b[1:0]);
    assign w_lh = mul2(i_a[1:0], i_b[3:2]);
    assign w_hl = mul2(i_a[3:2], i_b[1:0]);
    assign w_hh = mul2(i_a[3:2], i_b[3:2]);

    assign o_r_c = 8'(w_ll) + (8'(w_lh) << 2) + (8'(w_hl) << 2) + (8'(w_hh) << 4);

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Time-multiplexed 8x8 multiplier: four nibble products through one LM_2, shift-accumulated.
// Define MULT_SEQ_APPROX_ACC_EN to keep only the high nibble of the cross terms at weight 2^8.
module mult_8x8_seq_ctrl
    import mult_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_r,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [RES_W-1:0]   r_acc;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [NIB_W-1:0]   w_nib_a;
    logic [NIB_W-1:0]   w_nib_b;
    logic [2*NIB_W-1:0] w_prod;
    logic [RES_W-1:0]   w_add;
    logic               w_accept;
    logic               w_acc_en;

    LM_2 u_lm2 (
        .i_a   (w_nib_a),
        .i_b   (w_nib_b),
        .o_r_c (w_prod)
    );

    // Next state, nibble operand mux and weighted partial product.
    always_comb begin
        w_state_nxt = r_state;
        w_nib_a     = '0;
        w_nib_b     = '0;
        w_add       = '0;
        w_accept    = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_MUL0;
                end
            end
            ST_MUL0: begin
                w_nib_a     = r_a[3:0];
                w_nib_b     = r_b[3:0];
                w_add       = RES_W'(w_prod) << SH_P0;
                w_acc_en    = 1'b1;
                w_state_nxt = ST_MUL1;
            end
            ST_MUL1, ST_MUL2: begin
                w_nib_a  = (r_state == ST_MUL1) ? r_a[3:0] : r_a[7:4];
                w_nib_b  = (r_state == ST_MUL1) ? r_b[7:4] : r_b[3:0];
`ifdef MULT_SEQ_APPROX_ACC_EN
                w_add    = RES_W'(w_prod[7:4]) << SH_P3;
`else
                w_add    = RES_W'(w_prod) << SH_CROSS;
`endif
                w_acc_en = 1'b1;
                w_state_nxt = (r_state == ST_MUL1) ? ST_MUL2 : ST_MUL3;
            end
            ST_MUL3: begin
                w_nib_a     = r_a[7:4];
                w_nib_b     = r_b[7:4];
                w_add       = RES_W'(w_prod) << SH_P3;
                w_acc_en    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, operands, accumulator and flag outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_acc <= '0;
            end else if (w_acc_en) begin
                r_acc <= r_acc + w_add;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_r     = r_acc;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed and random bench for mult_8x8_seq_ctrl with a queue of expected products.
// Honours MULT_SEQ_APPROX_ACC_EN so both builds are checked against the matching model.
module tb_mult_8x8_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic        busy;

    int n_vec;
    int n_err;
    int cyc;
    int last_acc;
    int q[$];

    mult_8x8_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m2(input int x, input int y);
        if (x == 3 && y == 3) return 7;
        return x * y;
    endfunction

    function automatic int lm2_model(input int a, input int b);
        return m2(a % 4, b % 4) + 4 * (m2(a % 4, b / 4) + m2(a / 4, b % 4)) + 16 * m2(a / 4, b / 4);
    endfunction

    function automatic int mult_model(input int a, input int b);
        int p0, p1, p2, p3, s;
        p0 = lm2_model(a % 16, b % 16);
        p1 = lm2_model(a % 16, b / 16);
        p2 = lm2_model(a / 16, b % 16);
        p3 = lm2_model(a / 16, b / 16);
`ifdef MULT_SEQ_APPROX_ACC_EN
        s = p0 + 256 * (p1 / 16) + 256 * (p2 / 16) + 256 * p3;
`else
        s = p0 + 16 * p1 + 16 * p2 + 256 * p3;
`endif
        return s % 65536;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard bookkeeping for the coming edge, then advance to the next negedge.
    task automatic cycle();
        if (rst) begin
            q.delete();
            last_acc = -1;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_output", 32'(out_valid), 32'(0));
                else check("out_r", 32'(out_r), 32'(q.pop_front()));
            end
            if (in_valid && in_ready) begin
                q.push_back(mult_model(int'(in_a), int'(in_b)));
                if (last_acc >= 0) check("accept_spacing_ge6", 32'((cyc - last_acc) >= 6), 32'(1));
                last_acc = cyc;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() > 0 && k < budget) begin
            cycle();
            k++;
        end
        check("drain_timeout", 32'(q.size()), 32'(0));
    endtask

    initial begin
        logic [15:0] exp_p2;
        int          hold_exp;
        int          n_rand;
        int          guard;
        logic        took;

        n_vec = 0; n_err = 0; cyc = 0; last_acc = -1;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_out_r", 32'(out_r), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));

        // Zero operand, latency and ready timing.
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'h00; in_b = 8'hB7;
        cycle();
        in_valid = 1'b0; in_a = 8'hFF; in_b = 8'hFF;
        check("accept_busy", 32'(busy), 32'(1));
        check("accept_in_ready", 32'(in_ready), 32'(0));
        cycle(); cycle(); cycle();
        check("latency_not_early", 32'(out_valid), 32'(0));
        cycle();
        check("latency_valid", 32'(out_valid), 32'(1));
        check("zero_product", 32'(out_r), 32'(0));
        cycle();
        check("post_xfer_in_ready", 32'(in_ready), 32'(1));
        check("post_xfer_busy", 32'(busy), 32'(0));
        check("post_xfer_valid", 32'(out_valid), 32'(0));

        // Only the A-high x B-low cross term is non-zero.
`ifdef MULT_SEQ_APPROX_ACC_EN
        exp_p2 = 16'h0000;
`else
        exp_p2 = 16'h00F0;
`endif
        in_valid = 1'b1; in_a = 8'h30; in_b = 8'h05;
        cycle();
        in_valid = 1'b0;
        cycle(); cycle(); cycle();
        cycle();
        check("p2_only_value", 32'(out_r), 32'(exp_p2));
        drain(20);

        // Backpressure in DONE with operand churn.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h9C; in_b = 8'h6B;
        hold_exp = mult_model(32'h9C, 32'h6B);
        cycle();
        for (int k = 0; k < 20 && !out_valid; k++) cycle();
        check("bp_reach_done", 32'(out_valid), 32'(1));
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_a = 8'($urandom); in_b = 8'($urandom);
            cycle();
            check("bp_out_r_stable", 32'(out_r), 32'(hold_exp));
            check("bp_in_ready_low", 32'(in_ready), 32'(0));
        end
        check("bp_single_pending", 32'(q.size()), 32'(1));
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("bp_release_idle", 32'(in_ready), 32'(1));
        check("bp_release_valid", 32'(out_valid), 32'(0));
        check("bp_queue_empty", 32'(q.size()), 32'(0));
        cycle();
        check("bp_no_second_xfer", 32'(out_valid), 32'(0));

        // Reset in the middle of an operation.
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
        cycle();
        in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_r", 32'(out_r), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_busy", 32'(busy), 32'(0));
        for (int k = 0; k < 6; k++) cycle();
        check("midrst_discarded", 32'(out_valid), 32'(0));

        // Full-scale operands after reset.
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
        cycle();
        in_valid = 1'b0;
        drain(20);

        // Random back-to-back traffic with consumer stalls.
        n_rand = 0; guard = 0;
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
        while ((n_rand < 1000 || q.size() > 0) && guard < 30000) begin
            if (n_rand >= 1000) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            took = in_valid && in_ready;
            cycle();
            if (took) begin
                n_rand++;
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            guard++;
        end
        check("random_accepts", 32'(n_rand), 32'(1000));
        check("random_drained", 32'(q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
